line_window_gen: RTL and testbench
==================================

// Module: line_window_gen
// PURPOSE
//  Parametrised KxK sliding-window generator for raster pixel streams such as the grayscale output.
//  It holds K-1 line buffers in inferred RAM and a KxK register window, and emits one window per accepted pixel
//  once K-1 rows and K-1 columns of history exist. Windows never wrap across row boundaries.
//  Frame geometry is runtime-configurable. It feeds the convolution/filter stages (Sobel, median, Gaussian).
// PARAMETERS
//  DATA_W    8     pixel width in bits
//  KSIZE     3     window edge length; legal values are 3, 5 and 7
//  MAX_COLS  1024  line-buffer depth, i.e. the maximum frame width
//  CNT_W     11    width of the column/row counters and config ports; must hold MAX_COLS
// PORTS
//  clk        in   1                   clock, rising edge
//  rst_n      in   1                   asynchronous reset, active-low
//  cfg_cols   in   CNT_W               frame width in pixels; latched at frame start
//  cfg_rows   in   CNT_W               frame height in pixels; latched at frame start
//  in_valid   in   1                   in_data is valid this cycle (no backpressure; gaps allowed)
//  in_sof     in   1                   qualifies in_valid; this pixel is (row 0, col 0)
//  in_data    in   DATA_W              pixel
//  win_valid  out  1                   win_data holds a complete window
//  win_data   out  KSIZE*KSIZE*DATA_W  element (r,c) at [(r*KSIZE+c)*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the oldest column
//  win_eol    out  1                   with win_valid: window's newest pixel is the last column
//  win_eof    out  1                   with win_valid: window's newest pixel is the last pixel of the frame
//  cfg_err    out  1                   latched geometry is illegal; windows suppressed
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, window registers 0. Line-buffer RAM is not cleared; row gating makes stale data invisible.
//  - Reset mid-frame: the next pixel is treated as (0,0).
//  - Position: col/row counters advance only on in_valid.
//    - col wraps to 0 after cols-1 and row increments on that same pixel.
//    - After pixel (rows-1, cols-1), both counters return to 0.
//  - in_sof & in_valid: the pixel is (0,0) regardless of the counters, which resync from it. Config is latched on this pixel.
//  - Config latch: on in_sof, or on the first pixel of a frame, or after reset.
//    - Legal geometry: KSIZE <= cols <= MAX_COLS and rows >= KSIZE.
//    - If illegal: cfg_err=1 and win_valid is held 0 for the whole frame. cfg_err clears at the next legal latch.
//  - Line buffers: KSIZE-1 simple dual-port RAMs of depth MAX_COLS, addressed by col.
//    - Each accepted pixel reads all lines at col (1-cycle read latency).
//    - Line 0 is written with the pixel; line j is written with line j-1's read data. The pixel is delayed one cycle to align.
//  - Window: on the aligned strobe, the column vector {line K-2 .. line 0, pixel} shifts into c=K-1. Existing columns move toward c=0.
//  - Latency: win_valid is asserted exactly 2 clk after the in_valid cycle of the newest pixel. It is a 1-cycle pulse per qualifying pixel.
//  - Qualify: row >= KSIZE-1 && col >= KSIZE-1 && !cfg_err.
//    - First window per row: col = KSIZE-1. Windows per row: cols-KSIZE+1. Windows per frame: (cols-K+1)*(rows-K+1).
//  - win_data holds its value between pulses; it changes only on accepted pixels.
//  - Back-to-back pixels at full rate are sustained; read-during-write to the same address cannot occur because the address changes every pixel.
// CONFIGURATION
//  LWG_POS_OUT_EN
//  - Defined: adds ports win_col and win_row (out, CNT_W each).
//    - They carry the column and row of the window's newest pixel, aligned with win_valid. Reset value 0.
//  - Undefined: these ports and their pipeline registers do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package lwg_pkg: a function win_idx(r,c) returning the bit offset into win_data, a localparam for legal KSIZE, and a position-counter struct {col,row}.
//  - Sub-module lwg_line_ram: single-clock simple dual-port RAM with parameters DATA_W and DEPTH and registered read. It is instantiated KSIZE-1 times via generate.
//  - Top: position counters, config latch/check, 2-stage valid/position pipeline, and window shift registers.
// TESTING (KSIZE=3, DATA_W=8 unless stated; pixel value = row*16+col)
//  1. 8x6 frame, continuous in_valid:
//     - exactly 24 win_valid pulses.
//     - first pulse 2 clk after pixel (2,2), with win_data rows {00 01 02},{10 11 12},{20 21 22}.
//     - win_eol on cols 7; win_eof only on (5,7).
//  2. Same frame with in_valid toggling 1010 (random gaps): identical win_data sequence and pulse count; each pulse is 2 clk after its pixel.
//  3. Row boundary: there is no pulse for the newest pixel at col 0 or 1 of any row. The window at (3,2) contains no pixels from col 6/7.
//  4. Pulse in_sof at (3,4) mid-frame: counters resync, and the next pulse appears only after new pixel (2,2). Assert rst_n low mid-frame: all outputs 0 next cycle, clean restart.
//  5. cfg_cols=2: cfg_err=1 and zero pulses for the frame. The next frame with cfg_cols=8 clears cfg_err at its in_sof and produces 24 pulses.
//  6. KSIZE=5, cols=MAX_COLS=1024, rows=6:
//     - 2040 pulses; top-left of the first window = 0x00.
//     - With LWG_POS_OUT_EN: win_col/win_row = (4,4) on the first pulse and (1023,5) on the last.

Source files
------------

// File: rtl/lwg_pkg.sv
// Shared types and helpers for the KxK line-window generator.
//   LWG_POS_W       : internal width of the position counters and latched geometry.
//                     The top's CNT_W must not exceed this width.
//   LWG_KSIZE_LEGAL : bit k is set when KSIZE=k is a supported window size (3, 5, 7).
//   lwg_pos_t       : {col,row} raster position.
//   win_idx()       : bit offset of window element (r,c) inside the flattened window.
package lwg_pkg;

  localparam int         LWG_POS_W       = 16;
  localparam logic [7:0] LWG_KSIZE_LEGAL = 8'b1010_1000;

  typedef struct packed {
    logic [LWG_POS_W-1:0] col;
    logic [LWG_POS_W-1:0] row;
  } lwg_pos_t;

  function automatic int win_idx(input int r, input int c, input int ksize, input int data_w);
    return (r * ksize + c) * data_w;
  endfunction

endpackage

// File: rtl/lwg_line_ram.sv
// Single-clock simple dual-port line buffer with registered read.
//   clk         : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
// Contents are deliberately not reset.
module lwg_line_ram
  import lwg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_window_gen.sv
// KxK sliding-window generator for raster pixel streams.
// Holds KSIZE-1 line buffers plus a KxK register window and emits one window per
// accepted pixel once KSIZE-1 rows and columns of history exist in the current row/frame.
//   clk, rst_n          : clock, async active-low reset
//   cfg_cols, cfg_rows  : frame geometry, latched on in_sof or on the first pixel of a frame
//   in_valid/in_sof/in_data : pixel stream, no backpressure
//   win_valid/win_data  : window pulse (2 clk after the newest pixel) and window contents,
//                         element (r,c) at win_idx(r,c); r=0 oldest row, c=0 oldest column
//   win_eol/win_eof     : newest pixel is last column / last pixel of the frame
//   cfg_err             : latched geometry illegal, windows suppressed for the frame
// Optional macro LWG_POS_OUT_EN adds win_col/win_row (position of the newest pixel).
module line_window_gen
  import lwg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int KSIZE    = 3,
  parameter int MAX_COLS = 1024,
  parameter int CNT_W    = 11
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CNT_W-1:0]                cfg_cols,
  input  logic [CNT_W-1:0]                cfg_rows,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            win_valid,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   win_data,
  output logic                            win_eol,
  output logic                            win_eof,
`ifdef LWG_POS_OUT_EN
  output logic [CNT_W-1:0]                win_col,
  output logic [CNT_W-1:0]                win_row,
`endif
  output logic                            cfg_err
);

  localparam int PW = LWG_POS_W;
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int NL = KSIZE - 1;
  localparam logic [PW-1:0] K_P    = PW'(KSIZE);
  localparam logic [PW-1:0] KM1_P  = PW'(KSIZE - 1);
  localparam logic [PW-1:0] MAXC_P = PW'(MAX_COLS);
  localparam logic [PW-1:0] ONE_P  = PW'(1);

  // frame state
  lwg_pos_t          pos_q;
  logic [PW-1:0]     cols_q, rows_q;
  logic              err_q;

  // context of the pixel presented this cycle
  logic              latch, err_e, qual, eol, eof;
  lwg_pos_t          cur, nxt;
  logic [PW-1:0]     cols_e, rows_e;

  always_comb begin
    // counters at (0,0) mean either reset or the previous frame just completed
    latch  = in_valid && (in_sof || (pos_q == '0));
    cur    = in_sof ? '0 : pos_q;
    cols_e = latch ? PW'(cfg_cols) : cols_q;
    rows_e = latch ? PW'(cfg_rows) : rows_q;
    err_e  = latch ? !(cols_e >= K_P && cols_e <= MAXC_P && rows_e >= K_P) : err_q;
    eol    = (cur.col == cols_e - ONE_P);
    eof    = eol && (cur.row == rows_e - ONE_P);
    qual   = (cur.row >= KM1_P) && (cur.col >= KM1_P) && !err_e;
    nxt    = cur;
    if (eol) begin
      nxt.col = '0;
      nxt.row = eof ? '0 : cur.row + ONE_P;
    end else begin
      nxt.col = cur.col + ONE_P;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      cols_q <= '0;
      rows_q <= '0;
      err_q  <= 1'b0;
    end else if (in_valid) begin
      pos_q <= nxt;
      if (latch) begin
        cols_q <= cols_e;
        rows_q <= rows_e;
        err_q  <= err_e;
      end
    end
  end

  assign cfg_err = err_q;

  // stage 1: pixel delayed to line up with the RAM read data
  logic              stg1_vld, qual_d1, eol_d1, eof_d1;
  logic [DATA_W-1:0] pix_d1;
  logic [AW-1:0]     col_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg1_vld <= 1'b0;
      qual_d1  <= 1'b0;
      eol_d1   <= 1'b0;
      eof_d1   <= 1'b0;
      pix_d1   <= '0;
      col_d1   <= '0;
    end else begin
      stg1_vld <= in_valid;
      qual_d1  <= in_valid && qual;
      eol_d1   <= eol;
      eof_d1   <= eof;
      pix_d1   <= in_data;
      col_d1   <= cur.col[AW-1:0];
    end
  end

  // line j holds row (current-1-j); each line cascades into the next on write
  logic [NL-1:0][DATA_W-1:0] rd;

  for (genvar j = 0; j < NL; j++) begin : g_line
    logic [DATA_W-1:0] wd;
    if (j == 0) begin : g_first
      assign wd = pix_d1;
    end else begin : g_next
      assign wd = rd[j-1];
    end
    lwg_line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_COLS), .AW(AW)) u_line (
      .clk   (clk),
      .we    (stg1_vld),
      .waddr (col_d1),
      .wdata (wd),
      .re    (in_valid),
      .raddr (cur.col[AW-1:0]),
      .rdata (rd[j])
    );
  end

  // incoming column: oldest line at r=0, fresh pixel at r=KSIZE-1
  logic [KSIZE-1:0][DATA_W-1:0] col_vec;

  always_comb begin
    col_vec          = '0;
    col_vec[KSIZE-1] = pix_d1;
    for (int r = 0; r < KSIZE - 1; r++) col_vec[r] = rd[KSIZE-2-r];
  end

  // stage 2: window shift and output strobes
  logic [KSIZE*KSIZE*DATA_W-1:0] win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
      win_eof   <= 1'b0;
    end else begin
      win_valid <= qual_d1;
      win_eol   <= qual_d1 && eol_d1;
      win_eof   <= qual_d1 && eof_d1;
      if (stg1_vld) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++)
            win_q[win_idx(r, c, KSIZE, DATA_W) +: DATA_W] <= win_q[win_idx(r, c + 1, KSIZE, DATA_W) +: DATA_W];
          win_q[win_idx(r, KSIZE - 1, KSIZE, DATA_W) +: DATA_W] <= col_vec[r];
        end
      end
    end
  end

  assign win_data = win_q;

`ifdef LWG_POS_OUT_EN
  logic [CNT_W-1:0] col_p1, row_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p1  <= '0;
      row_p1  <= '0;
      win_col <= '0;
      win_row <= '0;
    end else begin
      col_p1 <= cur.col[CNT_W-1:0];
      row_p1 <= cur.row[CNT_W-1:0];
      if (qual_d1) begin
        win_col <= col_p1;
        win_row <= row_p1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_window_gen.sv
module tb_line_window_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] cfg_cols, cfg_rows;
  logic        in_valid3, in_sof3, in_valid5, in_sof5;
  logic [7:0]  in_data;

  logic         win_valid3, win_eol3, win_eof3, cfg_err3;
  logic [71:0]  win_data3;
  logic         win_valid5, win_eol5, win_eof5, cfg_err5;
  logic [199:0] win_data5;
`ifdef LWG_POS_OUT_EN
  logic [10:0]  win_col3, win_row3, win_col5, win_row5;
`endif

  always #5 clk = ~clk;

  line_window_gen #(.DATA_W(8), .KSIZE(3), .MAX_COLS(1024), .CNT_W(11)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid3), .in_sof(in_sof3), .in_data(in_data),
    .win_valid(win_valid3), .win_data(win_data3), .win_eol(win_eol3), .win_eof(win_eof3),
`ifdef LWG_POS_OUT_EN
    .win_col(win_col3), .win_row(win_row3),
`endif
    .cfg_err(cfg_err3)
  );

  line_window_gen #(.DATA_W(8), .KSIZE(5), .MAX_COLS(1024), .CNT_W(11)) dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid5), .in_sof(in_sof5), .in_data(in_data),
    .win_valid(win_valid5), .win_data(win_data5), .win_eol(win_eol5), .win_eof(win_eof5),
`ifdef LWG_POS_OUT_EN
    .win_col(win_col5), .win_row(win_row5),
`endif
    .cfg_err(cfg_err5)
  );

  typedef struct {
    logic [391:0] data;
    bit           eol;
    bit           eof;
    int           col;
    int           row;
    int           cyc;
  } exp_t;

  exp_t        q3[$], q5[$];
  exp_t        e3, e5;
  logic [71:0] log3[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0;
  int          p3, p5, eol3, eof3;
  logic [199:0] first5;
  int          first5_col, first5_row, last5_col, last5_row;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [391:0] got, input logic [391:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 16 + c) & 255);
  endfunction

  function automatic logic [391:0] exp_win(input int r, input int c, input int k);
    logic [391:0] w = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        w[(i * k + j) * 8 +: 8] = pix(r - k + 1 + i, c - k + 1 + j);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid3 = 1'b0; in_sof3 = 1'b0; in_valid5 = 1'b0; in_sof5 = 1'b0;
    end
  endtask

  // Drives npix pixels (all when npix<0) of a cols x rows frame and queues the
  // expected windows. gap!=0 inserts 1-2 idle cycles after every pixel.
  task automatic frame(input bit k5, input int cols, input int rows, input bit sof,
                       input bit gap, input int npix);
    int   k     = k5 ? 5 : 3;
    bit   legal = (cols >= k) && (cols <= 1024) && (rows >= k);
    int   total = (npix < 0) ? cols * rows : npix;
    exp_t e;
    cfg_cols = 11'(cols);
    cfg_rows = 11'(rows);
    for (int i = 0; i < total; i++) begin
      int r = i / cols;
      int c = i % cols;
      @(posedge clk); #1;
      if (k5) begin in_valid5 = 1'b1; in_sof5 = sof && (i == 0); end
      else    begin in_valid3 = 1'b1; in_sof3 = sof && (i == 0); end
      in_data = pix(r, c);
      if (legal && r >= k - 1 && c >= k - 1) begin
        e.data = exp_win(r, c, k);
        e.eol  = (c == cols - 1);
        e.eof  = e.eol && (r == rows - 1);
        e.col  = c;
        e.row  = r;
        e.cyc  = cyc + 2;
        if (k5) q5.push_back(e); else q3.push_back(e);
      end
      if (gap) idle(1 + $urandom_range(0, 1));
    end
    idle(1);
  endtask

  task automatic clr();
    p3 = 0; p5 = 0; eol3 = 0; eof3 = 0;
    log3.delete();
  endtask

  always @(negedge clk) begin
    if (win_valid3) begin
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL win3 unexpected: got a pulse at cyc %0d, expected none", cyc);
      end else begin
        e3 = q3.pop_front();
        chk("win3 data", 392'(win_data3), e3.data);
        chk("win3 latency cyc", 392'(cyc), 392'(e3.cyc));
        chk("win3 eol", 392'(win_eol3), 392'(e3.eol));
        chk("win3 eof", 392'(win_eof3), 392'(e3.eof));
`ifdef LWG_POS_OUT_EN
        chk("win3 col", 392'(win_col3), 392'(e3.col));
        chk("win3 row", 392'(win_row3), 392'(e3.row));
`endif
      end
      p3++;
      if (win_eol3) eol3++;
      if (win_eof3) eof3++;
      log3.push_back(win_data3);
    end else if (win_eol3 || win_eof3) begin
      n_tests++; n_fail++;
      $display("FAIL win3 strobe: got eol=%0b eof=%0b without win_valid, expected 0", win_eol3, win_eof3);
    end
  end

  always @(negedge clk) begin
    if (win_valid5) begin
      if (q5.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL win5 unexpected: got a pulse at cyc %0d, expected none", cyc);
      end else begin
        e5 = q5.pop_front();
        chk("win5 data", 392'(win_data5), e5.data);
        chk("win5 latency cyc", 392'(cyc), 392'(e5.cyc));
        chk("win5 eol", 392'(win_eol5), 392'(e5.eol));
        chk("win5 eof", 392'(win_eof5), 392'(e5.eof));
      end
      if (p5 == 0) first5 = win_data5;
`ifdef LWG_POS_OUT_EN
      if (p5 == 0) begin first5_col = int'(win_col5); first5_row = int'(win_row5); end
      last5_col = int'(win_col5);
      last5_row = int'(win_row5);
`endif
      p5++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cfg_cols = '0; cfg_rows = '0; in_data = '0;
    in_valid3 = 1'b0; in_sof3 = 1'b0; in_valid5 = 1'b0; in_sof5 = 1'b0;
    first5 = '1; first5_col = -1; first5_row = -1; last5_col = -1; last5_row = -1;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset win_valid", 392'(win_valid3), 392'(0));
    chk("reset win_data", 392'(win_data3), 392'(0));
    chk("reset eol/eof", 392'({win_eol3, win_eof3}), 392'(0));
    chk("reset cfg_err", 392'(cfg_err3), 392'(0));
    chk("reset win5_valid", 392'(win_valid5), 392'(0));
    rst_n = 1'b1;

    // continuous 8x6 frame
    clr();
    frame(0, 8, 6, 1, 0, -1);
    idle(4);
    chk("t1 pulses", 392'(p3), 392'(24));
    chk("t1 eol count", 392'(eol3), 392'(4));
    chk("t1 eof count", 392'(eof3), 392'(1));
    chk("t1 first window", 392'((log3.size() > 0) ? log3[0] : 72'bx),
        392'(72'h22_21_20_12_11_10_02_01_00));
    chk("t3 window at (3,2)", 392'((log3.size() > 6) ? log3[6] : 72'bx),
        392'(72'h32_31_30_22_21_20_12_11_10));
    chk("t1 queue drained", 392'(q3.size()), 392'(0));

    // same frame with gaps
    clr();
    frame(0, 8, 6, 1, 1, -1);
    idle(4);
    chk("t2 pulses", 392'(p3), 392'(24));
    chk("t2 queue drained", 392'(q3.size()), 392'(0));

    // in_sof arriving at (3,4): 8 pulses from the partial frame, 24 from the new one
    clr();
    frame(0, 8, 6, 1, 0, 28);
    frame(0, 8, 6, 1, 0, -1);
    idle(4);
    chk("t4 sof resync pulses", 392'(p3), 392'(32));
    chk("t4 sof queue drained", 392'(q3.size()), 392'(0));

    // reset mid-frame, then a frame without in_sof
    clr();
    frame(0, 8, 6, 1, 0, 20);
    idle(4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("t4 rst win_data", 392'(win_data3), 392'(0));
    chk("t4 rst strobes", 392'({win_valid3, win_eol3, win_eof3, cfg_err3}), 392'(0));
    idle(2);
    rst_n = 1'b1;
    frame(0, 8, 6, 0, 0, -1);
    idle(4);
    chk("t4 rst restart pulses", 392'(p3), 392'(26));
    chk("t4 rst queue drained", 392'(q3.size()), 392'(0));

    // illegal width, then a legal frame
    clr();
    frame(0, 2, 6, 1, 0, -1);
    idle(4);
    chk("t5 cfg_err set", 392'(cfg_err3), 392'(1));
    chk("t5 no pulses", 392'(p3), 392'(0));
    frame(0, 8, 6, 1, 0, -1);
    idle(4);
    chk("t5 cfg_err cleared", 392'(cfg_err3), 392'(0));
    chk("t5 recovery pulses", 392'(p3), 392'(24));
    chk("t5 queue drained", 392'(q3.size()), 392'(0));

    // KSIZE=5 at full width
    clr();
    frame(1, 1024, 6, 1, 0, -1);
    idle(4);
    chk("t6 pulses", 392'(p5), 392'(2040));
    chk("t6 top-left", 392'(first5[7:0]), 392'(8'h00));
    chk("t6 first window", 392'(first5), exp_win(4, 4, 5));
    chk("t6 queue drained", 392'(q5.size()), 392'(0));
    chk("t6 cfg_err", 392'(cfg_err5), 392'(0));
`ifdef LWG_POS_OUT_EN
    chk("t6 first col/row", 392'({first5_col, first5_row}), 392'({32'd4, 32'd4}));
    chk("t6 last col/row", 392'({last5_col, last5_row}), 392'({32'd1023, 32'd5}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
